// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with frame-aligned value commit,
// anti-ghosting dead time and optional leading-zero blanking.

module bcdDecoder (
  input  logic [3:0] hex,
  output logic [0:6] seg
);

  // Active-low segments, written a..g from left to right
  always_comb begin
    seg = 7'b1111111;
    case (hex)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      4'hF: seg = 7'b0111000;
      default: seg = 7'b1111111;
    endcase
  end

endmodule

module seg_scan_ctrl #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50000,
  parameter int GAP_CYC  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  blank_lz,
  output logic                  ready,
  output logic [DIGITS-1:0]     an,
  output logic [0:6]            seg,
  output logic                  frame
);

  localparam int CMAX = (PRESCALE > GAP_CYC) ? PRESCALE : GAP_CYC;
  localparam int CW   = $clog2(CMAX) + 1;
  localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic {GAP, ON} state_t;

  state_t              state, state_nx;
  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] disp, pend;
  logic                gap_done, on_done, wrap;
  logic                nonzero, blank;
  logic [3:0]          nib;
  logic [0:6]          dec;

  always_comb begin
    gap_done = (state == GAP) && (cnt == CW'(GAP_CYC - 1));
    on_done  = (state == ON) && (cnt == CW'(PRESCALE - 1));
    wrap     = on_done && (idx == IW'(DIGITS - 1));
    state_nx = state;
    if (gap_done)
      state_nx = ON;
    else if (on_done)
      state_nx = GAP;
  end

  // idx already points at the digit about to light while in GAP
  always_comb begin
    nib     = 4'h0;
    nonzero = 1'b0;
    for (int j = 0; j < DIGITS; j++) begin
      if (IW'(j) == idx)
        nib = disp[4*j +: 4];
      if ((j >= int'(idx)) && (disp[4*j +: 4] != 4'h0))
        nonzero = 1'b1;
    end
    blank = blank_lz && (idx != '0) && !nonzero;
  end

  bcdDecoder u_dec (
    .hex (nib),
    .seg (dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= GAP;
    else
      state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      idx   <= '0;
      disp  <= '0;
      pend  <= '0;
      ready <= 1'b1;
      an    <= '1;
      seg   <= '1;
      frame <= 1'b0;
    end else begin
      frame <= wrap;
      if (gap_done || on_done)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;

      if (gap_done) begin
        an  <= ~(DIGITS'(1) << idx);
        seg <= blank ? 7'b1111111 : dec;
      end else if (on_done) begin
        an  <= '1;
        seg <= '1;
        idx <= wrap ? '0 : idx + 1'b1;
      end

      // Accept and commit are mutually exclusive because both key off ready
      if (load && ready) begin
        pend  <= value;
        ready <= 1'b0;
      end else if (wrap && !ready) begin
        disp  <= pend;
        ready <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with DIGITS=4, PRESCALE=4, GAP_CYC=2 (24-cycle frame).

module tb_seg_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [15:0] value;
  logic        blank_lz;
  logic        ready;
  logic [3:0]  an;
  logic [0:6]  seg;
  logic        frame;

  int          compared;
  int          mismatched;
  int          edgeN;
  int          d;
  int          pulses;
  logic [0:6]  digs [4];
  logic [0:6]  want;

  seg_scan_ctrl #(
    .DIGITS   (4),
    .PRESCALE (4),
    .GAP_CYC  (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .value    (value),
    .blank_lz (blank_lz),
    .ready    (ready),
    .an       (an),
    .seg      (seg),
    .frame    (frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge n after reset release: digit k is lit after edges 2+6k .. 5+6k
  function automatic logic [3:0] exp_an(int n);
    if (n < 2) return 4'b1111;
    if (((n - 2) % 6) < 4) return ~(4'b0001 << (((n - 2) / 6) % 4));
    return 4'b1111;
  endfunction

  function automatic int exp_dig(int n);
    if (n < 2) return -1;
    if (((n - 2) % 6) < 4) return ((n - 2) / 6) % 4;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    edgeN++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    compared++;
    if (an !== 4'b1111) begin mismatched++; $display("[TB] FAIL reset_an: got %b want 1111", an); end
    compared++;
    if (seg !== 7'b1111111) begin mismatched++; $display("[TB] FAIL reset_seg: got %b want 1111111", seg); end
    compared++;
    if (ready !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_ready: got %b want 1", ready); end
    compared++;
    if (frame !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_frame: got %b want 0", frame); end
    rst_n = 1'b1;
    edgeN = 0;
    digs = '{7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001};
    for (int k = 0; k < 24; k++) begin
      tick();
      d = exp_dig(edgeN);
      want = 7'b1111111;
      if (d >= 0) want = digs[d];
      compared++;
      if (an !== exp_an(edgeN)) begin mismatched++; $display("[TB] FAIL first_scan_an n=%0d: got %b want %b", edgeN, an, exp_an(edgeN)); end
      compared++;
      if (seg !== want) begin mismatched++; $display("[TB] FAIL first_scan_seg n=%0d: got %b want %b", edgeN, seg, want); end
      compared++;
      if (frame !== (edgeN % 24 == 0)) begin mismatched++; $display("[TB] FAIL first_scan_frame n=%0d: got %b", edgeN, frame); end
    end
  endtask

  task automatic test_load_commit();
    load  = 1'b1;
    value = 16'h12AF;
    tick();
    load = 1'b0;
    compared++;
    if (ready !== 1'b0) begin mismatched++; $display("[TB] FAIL load_ready_fall: got %b want 0", ready); end
    digs = '{7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001};
    while (edgeN < 48) begin
      tick();
      d = exp_dig(edgeN);
      want = 7'b1111111;
      if (d >= 0) want = digs[d];
      compared++;
      if (seg !== want) begin mismatched++; $display("[TB] FAIL load_old_seg n=%0d: got %b want %b", edgeN, seg, want); end
    end
    compared++;
    if (ready !== 1'b1) begin mismatched++; $display("[TB] FAIL load_ready_rise: got %b want 1", ready); end
    digs = '{7'b0111000, 7'b0001000, 7'b0010010, 7'b1001111};
    for (int k = 0; k < 24; k++) begin
      tick();
      d = exp_dig(edgeN);
      want = 7'b1111111;
      if (d >= 0) want = digs[d];
      compared++;
      if (an !== exp_an(edgeN)) begin mismatched++; $display("[TB] FAIL load_an n=%0d: got %b want %b", edgeN, an, exp_an(edgeN)); end
      compared++;
      if (seg !== want) begin mismatched++; $display("[TB] FAIL load_seg n=%0d: got %b want %b", edgeN, seg, want); end
    end
  endtask

  task automatic test_ignored_load();
    load  = 1'b1;
    value = 16'h12AF;
    tick();
    load = 1'b0;
    while (edgeN < 80) tick();
    load  = 1'b1;
    value = 16'h3333;
    tick();
    load = 1'b0;
    compared++;
    if (ready !== 1'b0) begin mismatched++; $display("[TB] FAIL ignored_ready: got %b want 0", ready); end
    while (edgeN < 96) tick();
    compared++;
    if (ready !== 1'b1) begin mismatched++; $display("[TB] FAIL ignored_ready_rise: got %b want 1", ready); end
    digs = '{7'b0111000, 7'b0001000, 7'b0010010, 7'b1001111};
    for (int k = 0; k < 24; k++) begin
      tick();
      d = exp_dig(edgeN);
      want = 7'b1111111;
      if (d >= 0) want = digs[d];
      compared++;
      if (seg !== want) begin mismatched++; $display("[TB] FAIL ignored_seg n=%0d: got %b want %b", edgeN, seg, want); end
    end
  endtask

  task automatic test_blanking();
    blank_lz = 1'b1;
    load     = 1'b1;
    value    = 16'h0050;
    tick();
    load = 1'b0;
    while (edgeN < 144) tick();
    digs = '{7'b0000001, 7'b0100100, 7'b1111111, 7'b1111111};
    for (int k = 0; k < 24; k++) begin
      tick();
      d = exp_dig(edgeN);
      want = 7'b1111111;
      if (d >= 0) want = digs[d];
      compared++;
      if (an !== exp_an(edgeN)) begin mismatched++; $display("[TB] FAIL blank50_an n=%0d: got %b want %b", edgeN, an, exp_an(edgeN)); end
      compared++;
      if (seg !== want) begin mismatched++; $display("[TB] FAIL blank50_seg n=%0d: got %b want %b", edgeN, seg, want); end
    end
    load  = 1'b1;
    value = 16'h0000;
    tick();
    load = 1'b0;
    while (edgeN < 192) tick();
    digs = '{7'b0000001, 7'b1111111, 7'b1111111, 7'b1111111};
    for (int k = 0; k < 24; k++) begin
      tick();
      d = exp_dig(edgeN);
      want = 7'b1111111;
      if (d >= 0) want = digs[d];
      compared++;
      if (an !== exp_an(edgeN)) begin mismatched++; $display("[TB] FAIL blank00_an n=%0d: got %b want %b", edgeN, an, exp_an(edgeN)); end
      compared++;
      if (seg !== want) begin mismatched++; $display("[TB] FAIL blank00_seg n=%0d: got %b want %b", edgeN, seg, want); end
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_frame_pulse();
    pulses = 0;
    for (int k = 0; k < 48; k++) begin
      tick();
      if (frame === 1'b1) pulses++;
      compared++;
      if (frame !== (edgeN % 24 == 0)) begin mismatched++; $display("[TB] FAIL frame_pulse n=%0d: got %b want %b", edgeN, frame, (edgeN % 24 == 0)); end
      compared++;
      if (an !== exp_an(edgeN)) begin mismatched++; $display("[TB] FAIL frame_an n=%0d: got %b want %b", edgeN, an, exp_an(edgeN)); end
    end
    compared++;
    if (pulses != 2) begin mismatched++; $display("[TB] FAIL frame_count: got %0d want 2", pulses); end
  endtask

  task automatic test_reset_mid();
    load  = 1'b1;
    value = 16'h4321;
    tick();
    load = 1'b0;
    while (edgeN < 279) tick();
    compared++;
    if (an !== 4'b1011) begin mismatched++; $display("[TB] FAIL mid_digit2_an: got %b want 1011", an); end
    #3;
    rst_n = 1'b0;
    #1;
    compared++;
    if (an !== 4'b1111) begin mismatched++; $display("[TB] FAIL mid_reset_an: got %b want 1111", an); end
    compared++;
    if (seg !== 7'b1111111) begin mismatched++; $display("[TB] FAIL mid_reset_seg: got %b want 1111111", seg); end
    compared++;
    if (ready !== 1'b1) begin mismatched++; $display("[TB] FAIL mid_reset_ready: got %b want 1", ready); end
    compared++;
    if (frame !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_reset_frame: got %b want 0", frame); end
    repeat (2) @(posedge clk);
    #1;
    compared++;
    if (an !== 4'b1111) begin mismatched++; $display("[TB] FAIL mid_reset_hold_an: got %b want 1111", an); end
    rst_n = 1'b1;
    edgeN = 0;
    digs = '{7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001};
    for (int k = 0; k < 48; k++) begin
      tick();
      d = exp_dig(edgeN);
      want = 7'b1111111;
      if (d >= 0) want = digs[d];
      compared++;
      if (an !== exp_an(edgeN)) begin mismatched++; $display("[TB] FAIL restart_an n=%0d: got %b want %b", edgeN, an, exp_an(edgeN)); end
      compared++;
      if (seg !== want) begin mismatched++; $display("[TB] FAIL restart_seg n=%0d: got %b want %b", edgeN, seg, want); end
      compared++;
      if (ready !== 1'b1) begin mismatched++; $display("[TB] FAIL restart_ready n=%0d: got %b want 1", edgeN, ready); end
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    edgeN      = 0;
    rst_n      = 1'b0;
    load       = 1'b0;
    value      = 16'h0000;
    blank_lz   = 1'b0;
    $display("[TB] starting seg_scan_ctrl bench");
    test_reset();
    test_load_commit();
    test_ignored_load();
    test_blanking();
    test_frame_pulse();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
